// File: rtl/microcpu_pkg.sv
// Shared types for the memory-access stage: FSM encoding, latched-op record, timeout default.
package microcpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        reg_we;
    logic [4:0]  dest;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles; expired is combinational and high during the LIMIT-th enabled cycle.
// No backpressure; clear has priority over enable.
module mem_timeout_counter
  import microcpu_pkg::*;
#(
  parameter int LIMIT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  // cnt holds the number of already-completed WAIT cycles, so the current cycle is cnt+1
  assign expired = enable && (cnt >= 4'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: ALU ops write back after 1 cycle, loads/stores wait for mem_ack or timeout.
// stall is high for every WAIT cycle; inputs are ignored while stalled.
module mem_access_stage
  import microcpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic        in_reg_write_enable,
  input  logic [4:0]  in_alu_dest,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_wb_enable,
  output logic [4:0]  out_wb_dest,
  output logic [31:0] out_wb_data,
  output logic        out_mem_err
);

  mem_state_t state, state_nxt;
  mem_op_t    op_q;
  logic       squash;
  logic       expired;

  logic in_wait;
  logic accept;
  logic accept_mem;
  logic ack_done;
  logic timeout;

  assign in_wait    = (state == ST_WAIT);
  assign accept     = !in_wait && in_valid && !flush;
  assign accept_mem = accept && (in_mem_rd || in_mem_wr);
  assign ack_done   = in_wait && mem_ack;
  assign timeout    = in_wait && !mem_ack && expired;

  mem_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_mem),
    .enable  (in_wait),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_mem) state_nxt = ST_WAIT;
      ST_WAIT: if (ack_done || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read wins when both rd and wr are asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (accept_mem) begin
      op_q.rd     <= in_mem_rd;
      op_q.wr     <= in_mem_wr && !in_mem_rd;
      op_q.reg_we <= in_reg_write_enable;
      op_q.dest   <= in_alu_dest;
      op_q.addr   <= in_alu_result;
      op_q.wdata  <= in_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash <= 1'b0;
    end else if (accept_mem) begin
      squash <= 1'b0;
    end else if (in_wait && flush) begin
      squash <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wb_enable <= 1'b0;
      out_wb_dest   <= '0;
      out_wb_data   <= '0;
      out_mem_err   <= 1'b0;
    end else begin
      out_wb_enable <= 1'b0;
      out_mem_err   <= timeout;
      if (accept && !accept_mem) begin
        out_wb_enable <= in_reg_write_enable;
        out_wb_dest   <= in_alu_dest;
        out_wb_data   <= in_alu_result;
      end else if (ack_done && op_q.rd) begin
        // a flush arriving on the ack cycle itself still kills the writeback
        out_wb_enable <= op_q.reg_we && !(squash || flush);
        out_wb_dest   <= op_q.dest;
        out_wb_data   <= mem_rdata;
      end
    end
  end

  assign mem_req   = in_wait;
  assign stall     = in_wait;
  assign mem_we    = in_wait && op_q.wr;
  assign mem_addr  = op_q.addr;
  assign mem_wdata = op_q.wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with immediate-assertion checks.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        in_mem_rd = 1'b0;
  logic        in_mem_wr = 1'b0;
  logic        in_reg_write_enable = 1'b0;
  logic [4:0]  in_alu_dest = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_store_data = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, mem_req, mem_we, out_wb_enable, out_mem_err;
  logic [31:0] mem_addr, mem_wdata, out_wb_data;
  logic [4:0]  out_wb_dest;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .flush               (flush),
    .in_mem_rd           (in_mem_rd),
    .in_mem_wr           (in_mem_wr),
    .in_reg_write_enable (in_reg_write_enable),
    .in_alu_dest         (in_alu_dest),
    .in_alu_result       (in_alu_result),
    .in_store_data       (in_store_data),
    .stall               (stall),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .out_wb_enable       (out_wb_enable),
    .out_wb_dest         (out_wb_dest),
    .out_wb_data         (out_wb_data),
    .out_mem_err         (out_mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic [31:0] sdata);
    in_valid = 1'b1;
    in_mem_rd = rd;
    in_mem_wr = wr;
    in_reg_write_enable = we;
    in_alu_dest = dest;
    in_alu_result = res;
    in_store_data = sdata;
    tick();
    in_valid = 1'b0;
    in_mem_rd = 1'b0;
    in_mem_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_en", out_wb_enable, 0);
    check("rst_err", out_mem_err, 0);
    check("rst_wb_data", out_wb_data, 0);
    tick();
    rst_n = 1'b1;

    // ALU op
    issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h0);
    check("alu_wb_en", out_wb_enable, 1);
    check("alu_wb_dest", out_wb_dest, 3);
    check("alu_wb_data", out_wb_data, 32'h1234);
    check("alu_stall", stall, 0);
    tick();
    check("alu_wb_pulse", out_wb_enable, 0);
    check("alu_data_hold", out_wb_data, 32'h1234);

    // Load, ack in the 3rd WAIT cycle
    issue(1'b1, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0);
    check("ld_wb_en_entry", out_wb_enable, 0);
    check("ld_we", mem_we, 0);
    check("ld_addr", mem_addr, 32'h100);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("ld_stall_c%0d", c), stall, 1);
      check($sformatf("ld_req_c%0d", c), mem_req, 1);
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("ld_stall_done", stall, 0);
    check("ld_wb_en", out_wb_enable, 1);
    check("ld_wb_dest", out_wb_dest, 5);
    check("ld_wb_data", out_wb_data, 32'hDEADBEEF);

    // Store, ack on the first WAIT cycle
    issue(1'b0, 1'b1, 1'b0, 5'd9, 32'h200, 32'hA5A5A5A5);
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 32'h200);
    check("st_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_stall_done", stall, 0);
    check("st_wb_en", out_wb_enable, 0);
    check("st_data_hold", out_wb_data, 32'hDEADBEEF);

    // rd and wr together behave as a read
    issue(1'b1, 1'b1, 1'b1, 5'd6, 32'h300, 32'hFFFF0000);
    check("rw_we", mem_we, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h11;
    tick();
    mem_ack = 1'b0;
    check("rw_wb_en", out_wb_enable, 1);
    check("rw_wb_data", out_wb_data, 32'h11);

    // Load with no ack: 15 WAIT cycles then error
    issue(1'b1, 1'b0, 1'b1, 5'd8, 32'h400, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("to_req_c%0d", c), mem_req, 1);
      check($sformatf("to_err_c%0d", c), out_mem_err, 0);
      tick();
    end
    check("to_req_drop", mem_req, 0);
    check("to_err_pulse", out_mem_err, 1);
    check("to_wb_en", out_wb_enable, 0);
    tick();
    check("to_err_one_cycle", out_mem_err, 0);

    // Ack on the 15th WAIT cycle wins
    issue(1'b1, 1'b0, 1'b1, 5'd10, 32'h500, 32'h0);
    for (int c = 1; c <= 14; c++) tick();
    check("ack15_req", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000CAFE;
    tick();
    mem_ack = 1'b0;
    check("ack15_err", out_mem_err, 0);
    check("ack15_wb_en", out_wb_enable, 1);
    check("ack15_wb_data", out_wb_data, 32'h0000CAFE);
    check("ack15_req_drop", mem_req, 0);

    // Flush in 2nd WAIT cycle, ack on the 4th
    issue(1'b1, 1'b0, 1'b1, 5'd12, 32'h600, 32'h0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_still_wait", stall, 1);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    check("fl_done", stall, 0);
    check("fl_wb_en", out_wb_enable, 0);
    check("fl_err", out_mem_err, 0);

    // Flush in IDLE accepts nothing
    flush = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 5'd13, 32'h700, 32'h0);
    flush = 1'b0;
    check("fli_stall", stall, 0);
    check("fli_wb_en", out_wb_enable, 0);

    // Reset in the middle of WAIT
    issue(1'b1, 1'b0, 1'b1, 5'd14, 32'h800, 32'h0);
    tick();
    check("rw_pre_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_req", mem_req, 0);
    check("mrst_stall", stall, 0);
    check("mrst_wb_data", out_wb_data, 0);
    check("mrst_wb_dest", out_wb_dest, 0);
    check("mrst_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0);
    check("post_rst_wb_en", out_wb_enable, 1);
    check("post_rst_wb_dest", out_wb_dest, 7);
    check("post_rst_wb_data", out_wb_data, 32'h55);
    issue(1'b1, 1'b0, 1'b1, 5'd2, 32'h900, 32'h0);
    check("post_rst_ld_req", mem_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
